yd_wb_arb: RTL and testbench
============================

Name: yd_wb_arb

Overview:
Writeback arbiter that shares the register file's two write ports (port 0 and port 1) among three requesters: r0 = ALU, r1 = second ALU, r2 = load return.
- Grants up to two writes per cycle.
- Never presents two writes to the same register address in one cycle, so the register file's port-0-wins conflict rule is never exercised.
- Registers the write-port outputs.
- Sits between execute/load units and the register file; hold is driven by the pipeline stall logic.

Parameters:
DW, 16, data width of each write.
AW, 4, register address width; address 0 is the hard-zero register.
RR_EN, 1, 1 = round-robin priority; 0 = fixed priority r0 > r1 > r2.
CW, 8, width of the saturating conflict counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
hold  in  1  stall; when 1, no request is accepted.
rN_v  in  1  requester N (N = 0, 1, 2) has a write pending.
rN_addr  in  AW  requester N destination register.
rN_data  in  DW  requester N write data.
rN_rdy  out  1  combinational; requester N's write is accepted this cycle.
we0  out  1  register file write enable, port 0 (registered).
waddr0  out  AW  port 0 address (registered).
din0  out  DW  port 0 data (registered).
we1  out  1  register file write enable, port 1 (registered).
waddr1  out  AW  port 1 address (registered).
din1  out  DW  port 1 data (registered).
conf_cnt  out  CW  saturating count of cycles with an address-conflict refusal.

Behaviour:
- Transfer: occurs when rN_v && rN_rdy. Requesters hold v/addr/data stable until accepted. rN_rdy must not depend on rN_rdy of any requester.
- Reset: all outputs and state go to 0 (we0 = we1 = 0, waddrX = 0, dinX = 0, ptr = 0, conf_cnt = 0). rdy = 0 while rst = 1.
- hold = 1:
  - all rdy = 0.
  - Next-cycle we0 = we1 = 0; ptr and conf_cnt unchanged.
- Zero-address requests (v = 1, addr = 0): rdy = 1 (when hold = 0), consume no port, produce no write.
- Candidates: requesters with v = 1 and addr != 0.
- Scan order:
  - RR_EN = 1: ptr, ptr+1, ptr+2 (mod 3).
  - RR_EN = 0: 0, 1, 2.
- Port assignment:
  - Port 0 = first candidate in scan order.
  - Port 1 = next candidate in scan order whose addr differs from port 0's addr.
  - Every other candidate gets rdy = 0.
- Output latency is 1 cycle. On the edge after an accepted transfer:
  - port 0: we0 = 1, waddr0/din0 = the granted request.
  - port 1: we1 = 1, waddr1/din1 = the granted request.
  - Unused port: we = 0; its addr/data hold their previous values.
- ptr update (RR_EN = 1): if any port is granted, ptr ← (index of the last granted requester in scan order + 1) mod 3. Otherwise ptr is unchanged. ptr is a 2-bit register with values 0–2 only.
- conf_cnt: +1 on each cycle (hold = 0) where at least one candidate is refused because its addr equals port 0's addr. Saturates at all-ones.
- A candidate refused only because both ports are taken does not count toward conf_cnt.
- Three candidates with three distinct addresses: two granted, the third waits. Round-robin guarantees the third is granted within 2 cycles if it stays valid.
- Same-address pair: only one is granted per cycle. The writes go out in scan order on consecutive cycles, so the last-written value is deterministic.
- Reset asserted mid-stream: pending outputs are discarded; we0 = we1 = 0 on the following edge.

Test Plan:
1. Reset, then r0 = (2, 0x1111), r1 = (3, 0x2222), r2 idle → r0_rdy = r1_rdy = 1; next cycle we0 = 1 waddr0 = 2 din0 = 0x1111, we1 = 1 waddr1 = 3 din1 = 0x2222; ptr = 2.
2. ptr = 0; all three valid, addrs 4/5/6 → cycle 1 grants r0 (port 0) and r1 (port 1), r2_rdy = 0. Cycle 2 (ptr = 2) grants r2 on port 0. conf_cnt stays 0.
3. ptr = 0; r0 and r1 both target addr 7, data 0xAAAA / 0xBBBB → cycle 1 writes 7 = 0xAAAA on port 0, we1 = 0, conf_cnt = 1. Next cycle writes 7 = 0xBBBB. Final register value is 0xBBBB.
4. r1 = (0, 0x5555), r2 = (8, 0x0F0F) → r1_rdy = 1 with no write; r2 goes to port 0; we1 = 0.
5. hold = 1 with all requests valid for 3 cycles → all rdy = 0 and we0 = we1 = 0. Release hold → grants resume from the unchanged ptr.
6. Force 300 conflict cycles with CW = 8 → conf_cnt = 255 and holds there. Assert rst mid-stream → all outputs 0 the next cycle.

Source files
------------

// File: rtl/yd_wb_arb.sv
// yd_wb_arb: shares two register-file write ports among three writeback
// requesters, never issuing two writes to the same register in one cycle.
module yd_wb_arb #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int RR_EN = 1,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          r0_v,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_data,
    output logic          r0_rdy,
    input  logic          r1_v,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_data,
    output logic          r1_rdy,
    input  logic          r2_v,
    input  logic [AW-1:0] r2_addr,
    input  logic [DW-1:0] r2_data,
    output logic          r2_rdy,
    output logic          we0,
    output logic [AW-1:0] waddr0,
    output logic [DW-1:0] din0,
    output logic          we1,
    output logic [AW-1:0] waddr1,
    output logic [DW-1:0] din1,
    output logic [CW-1:0] conf_cnt
);

    logic [2:0]    v;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] data [3];
    logic [2:0]    cand;
    logic [2:0]    zero;
    logic [2:0]    rdy;
    logic [1:0]    ord [3];
    logic [1:0]    ptr;
    logic          act;
    logic          g0_v;
    logic          g1_v;
    logic [1:0]    g0_i;
    logic [1:0]    g1_i;
    logic          conf;
    logic [1:0]    last;
    logic [1:0]    nxt;

    assign v       = {r2_v, r1_v, r0_v};
    assign addr[0] = r0_addr;
    assign addr[1] = r1_addr;
    assign addr[2] = r2_addr;
    assign data[0] = r0_data;
    assign data[1] = r1_data;
    assign data[2] = r2_data;
    assign act     = !rst && !hold;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            zero[i] = v[i] && (addr[i] == '0);
            cand[i] = v[i] && (addr[i] != '0);
        end
    end

    // Scan order starts at ptr and wraps modulo 3.
    always_comb begin
        if (RR_EN != 0) begin
            ord[0] = ptr;
            ord[1] = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
            ord[2] = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        end else begin
            ord[0] = 2'd0;
            ord[1] = 2'd1;
            ord[2] = 2'd2;
        end
    end

    always_comb begin
        g0_v = 1'b0;
        g1_v = 1'b0;
        g0_i = 2'd0;
        g1_i = 2'd0;
        conf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (cand[ord[k]]) begin
                if (!g0_v) begin
                    g0_v = 1'b1;
                    g0_i = ord[k];
                end else if (addr[ord[k]] == addr[g0_i]) begin
                    conf = 1'b1;
                end else if (!g1_v) begin
                    g1_v = 1'b1;
                    g1_i = ord[k];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rdy[i] = act && (zero[i]
                     || (g0_v && g0_i == 2'(i))
                     || (g1_v && g1_i == 2'(i)));
        end
    end

    assign r0_rdy = rdy[0];
    assign r1_rdy = rdy[1];
    assign r2_rdy = rdy[2];

    assign last = g1_v ? g1_i : g0_i;
    assign nxt  = (last == 2'd2) ? 2'd0 : last + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            we0      <= 1'b0;
            waddr0   <= '0;
            din0     <= '0;
            we1      <= 1'b0;
            waddr1   <= '0;
            din1     <= '0;
            ptr      <= 2'd0;
            conf_cnt <= '0;
        end else begin
            we0 <= act && g0_v;
            we1 <= act && g1_v;
            if (act && g0_v) begin
                waddr0 <= addr[g0_i];
                din0   <= data[g0_i];
            end
            if (act && g1_v) begin
                waddr1 <= addr[g1_i];
                din1   <= data[g1_i];
            end
            if (act && g0_v && RR_EN != 0) begin
                ptr <= nxt;
            end
            if (act && conf && conf_cnt != '1) begin
                conf_cnt <= conf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_yd_wb_arb.sv
// tb_yd_wb_arb: directed plan plus random traffic against a queue-based
// reference model; a monitor compares registered outputs from a scoreboard.
module tb_yd_wb_arb;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          hold;
    logic [2:0]    rv;
    logic [2:0]    rdy;
    logic [AW-1:0] ra [3];
    logic [DW-1:0] rd [3];
    logic          we0;
    logic          we1;
    logic [AW-1:0] waddr0;
    logic [AW-1:0] waddr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [CW-1:0] conf_cnt;

    yd_wb_arb #(.DW(DW), .AW(AW), .RR_EN(1), .CW(CW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .r0_v(rv[0]), .r0_addr(ra[0]), .r0_data(rd[0]), .r0_rdy(rdy[0]),
        .r1_v(rv[1]), .r1_addr(ra[1]), .r1_data(rd[1]), .r1_rdy(rdy[1]),
        .r2_v(rv[2]), .r2_addr(ra[2]), .r2_data(rd[2]), .r2_rdy(rdy[2]),
        .we0(we0), .waddr0(waddr0), .din0(din0),
        .we1(we1), .waddr1(waddr1), .din1(din1),
        .conf_cnt(conf_cnt)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          expq[$];
    exp_t          em;
    int            checks = 0;
    int            errors = 0;
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_a0 = '0;
    logic [AW-1:0] m_a1 = '0;
    logic [DW-1:0] m_d0 = '0;
    logic [DW-1:0] m_d1 = '0;
    logic [2:0]    acc;
    logic [DW-1:0] rf [16];

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    // Reference: build scan order, keep candidates, pick first, then the
    // first remaining candidate with a different address.
    task automatic step();
        int   ord[$];
        int   cands[$];
        int   diff[$];
        int   same[$];
        int   g0;
        int   g1;
        logic [2:0] er;
        exp_t e;
        #1;
        g0 = -1;
        g1 = -1;
        er = '0;
        if (rst) begin
            m_ptr = 0;
            m_cnt = 0;
            m_a0  = '0;
            m_a1  = '0;
            m_d0  = '0;
            m_d1  = '0;
        end else if (!hold) begin
            for (int k = 0; k < 3; k++) ord.push_back((m_ptr + k) % 3);
            foreach (ord[k]) begin
                if (rv[ord[k]]) begin
                    if (ra[ord[k]] == 0) er[ord[k]] = 1'b1;
                    else cands.push_back(ord[k]);
                end
            end
            if (cands.size() > 0) begin
                g0 = cands.pop_front();
                er[g0] = 1'b1;
                diff = cands.find(x) with (ra[x] != ra[g0]);
                same = cands.find(x) with (ra[x] == ra[g0]);
                if (diff.size() > 0) begin
                    g1 = diff[0];
                    er[g1] = 1'b1;
                    m_a1 = ra[g1];
                    m_d1 = rd[g1];
                end
                if (same.size() > 0 && m_cnt < MAX) m_cnt++;
                m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % 3;
                m_a0 = ra[g0];
                m_d0 = rd[g0];
            end
        end
        e.we0 = (g0 >= 0);
        e.a0  = m_a0;
        e.d0  = m_d0;
        e.we1 = (g1 >= 0);
        e.a1  = m_a1;
        e.d1  = m_d1;
        e.cnt = CW'(m_cnt);
        expq.push_back(e);
        for (int i = 0; i < 3; i++) chk($sformatf("rdy%0d", i), rdy[i], er[i]);
        acc = rv & er;
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            em = expq.pop_front();
            chk("we0", we0, em.we0);
            chk("waddr0", waddr0, em.a0);
            chk("din0", din0, em.d0);
            chk("we1", we1, em.we1);
            chk("waddr1", waddr1, em.a1);
            chk("din1", din1, em.d1);
            chk("conf_cnt", conf_cnt, em.cnt);
            if (we1) rf[waddr1] = din1;
            if (we0) rf[waddr0] = din0;
        end
    end

    task automatic run();
        step();
        @(negedge clk);
        rv = rv & ~acc;
    endtask

    task automatic req(input int i, input int a, input int d);
        rv[i] = 1'b1;
        ra[i] = AW'(a);
        rd[i] = DW'(d);
    endtask

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        rv   = '0;
        acc  = '0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        @(negedge clk);
        run();
        run();
        rst = 1'b0;

        req(0, 2, 16'h1111);
        req(1, 3, 16'h2222);
        run();
        run();

        rst = 1'b1;
        run();
        rst = 1'b0;
        req(0, 4, 16'h0404);
        req(1, 5, 16'h0505);
        req(2, 6, 16'h0606);
        run();
        run();
        run();

        rst = 1'b1;
        run();
        rst = 1'b0;
        req(0, 7, 16'hAAAA);
        req(1, 7, 16'hBBBB);
        run();
        run();
        run();
        chk("rf7_last", rf[7], 16'hBBBB);

        req(1, 0, 16'h5555);
        req(2, 8, 16'h0F0F);
        run();
        run();

        hold = 1'b1;
        req(0, 10, 16'h1010);
        req(1, 11, 16'h1111);
        req(2, 12, 16'h1212);
        repeat (3) run();
        hold = 1'b0;
        repeat (3) run();

        repeat (300) begin
            if (!rv[0]) req(0, 9, int'($urandom));
            if (!rv[1]) req(1, 9, int'($urandom));
            run();
        end
        chk("conf_sat", conf_cnt, MAX);
        rst = 1'b1;
        run();
        rst = 1'b0;
        rv = '0;
        chk("rst_cnt", conf_cnt, 0);

        repeat (2000) begin
            hold = ($urandom % 8) == 0;
            rst  = ($urandom % 200) == 0;
            for (int i = 0; i < 3; i++) begin
                if (!rv[i] && ($urandom % 3) != 0)
                    req(i, int'($urandom % 5), int'($urandom));
            end
            run();
        end
        rst  = 1'b0;
        hold = 1'b0;
        rv   = '0;
        run();
        run();
        repeat (5) if (expq.size() > 0) @(negedge clk);
        chk("drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
